cpu_mem_bus_arbiter: RTL and testbench
======================================

Name: cpu_mem_bus_arbiter

Overview:
Registered two-requester arbiter between the core's dcache and icache miss paths and the single shared memory bus. It replaces the combinational/latched request and response router in the core. The arbiter issues one transaction at a time, tags it with a requester id (0 = dcache, 1 = icache) and routes the tagged response back. Dcache has fixed priority, with a bounded-starvation guarantee for icache.

Parameters:
ADDR_WIDTH, 32, memory bus address width
DATA_WIDTH, 128, memory bus data width (one cache line)
MAX_D_STREAK, 4, consecutive dcache grants allowed while icache waits
TIMEOUT_CYCLES, 256, maximum cycles in WAIT before the transaction is abandoned

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
d_req_read  in  1  dcache read request; held until d_grant
d_req_write  in  1  dcache write request; held until d_grant
d_req_addr  in  ADDR_WIDTH  dcache request address
d_req_data  in  DATA_WIDTH  dcache write data
d_grant  out  1  one-cycle pulse: dcache request accepted
d_resp_valid  out  1  dcache response valid
d_resp_addr  out  ADDR_WIDTH  response address
d_resp_data  out  DATA_WIDTH  response data
i_req_read, i_req_write, i_req_addr, i_req_data  in  1/1/ADDR_WIDTH/DATA_WIDTH  icache request; same rules as dcache
i_grant  out  1  icache accepted pulse
i_resp_valid, i_resp_addr, i_resp_data  out  1/ADDR_WIDTH/DATA_WIDTH  icache response
mem_req_id  out  1  id of the issued transaction
mem_req_read  out  1  memory read strobe
mem_req_write  out  1  memory write strobe
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_data  out  DATA_WIDTH  memory write data
mem_resp_valid  in  1  memory response valid
mem_resp_id  in  1  response id
mem_resp_addr  in  ADDR_WIDTH  response address
mem_resp_data  in  DATA_WIDTH  response data
busy  out  1  transaction in flight (state != IDLE)
timeout_err  out  1  sticky: a WAIT timed out
spurious_err  out  1  sticky: response with no matching outstanding id

Behaviour:
- Reset (async) puts the FSM in IDLE and clears every registered output: mem_req_*, grants, streak, timeout counter, sticky flags and pending id all go to 0.
- FSM states:
  - IDLE: winner = dcache if it requests, unless streak == MAX_D_STREAK and icache also requests; otherwise icache. The winner's grant pulses combinationally in this cycle. Its id, addr, data and strobes are captured into registers, and the FSM goes to REQ.
  - REQ: mem_req_read or mem_req_write is high for exactly this one cycle, with id/addr/data valid. Then go to WAIT.
  - WAIT: on mem_resp_valid with mem_resp_id == pending id, go to IDLE.
- mem_req_addr, mem_req_data and mem_req_id hold their values until the next capture. Strobes are 0 outside REQ.
- A requester asserting read and write together: the write is issued and the read is dropped.
- Both reads and writes complete only on a matching response. Minimum issue-to-issue spacing is 3 cycles: IDLE, REQ, then a WAIT cycle in which the response arrives.
- Response routing is combinational. x_resp_valid = mem_resp_valid && state == WAIT && id match; addr and data pass through. A response in the REQ cycle is treated as spurious.
- Non-matching response, or any response outside WAIT: dropped, spurious_err set.
- Streak (saturating at MAX_D_STREAK):
  - incremented on a dcache grant while icache is requesting;
  - cleared on an icache grant, or in any IDLE cycle where icache is not requesting.
- Timeout counter: cleared on entering WAIT, incremented each WAIT cycle. On reaching TIMEOUT_CYCLES-1 without a response, go to IDLE, set timeout_err, send no response. A later response for the abandoned id counts as spurious.
- Sticky flags clear only on reset.
- Reset mid-transaction aborts it; no grant or response is generated for it.

Test Plan:
- Single dcache read at addr 0x100 → d_grant in cycle 0, mem_req_read=1 with id=0 and addr 0x100 in cycle 1; response id 0, data 0xAB in cycle 3 → d_resp_valid=1 and data 0xAB in that cycle, i_resp_valid=0.
- Dcache and icache both request in the same IDLE cycle → dcache granted first. Icache is granted at the first IDLE after the dcache response, with mem_req_id=1.
- Dcache requests continuously while icache requests continuously, MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I.
- In WAIT for id 1, inject a response with id 0 → no resp_valid on either side, spurious_err=1, FSM still in WAIT. A subsequent id 1 response completes normally.
- No response for TIMEOUT_CYCLES=8 → FSM returns to IDLE after 8 WAIT cycles, timeout_err=1; a queued icache request is then granted.
- Assert reset asynchronously (mid-cycle) during WAIT → busy and all strobes drop to 0 immediately, without waiting for a clock edge; a late response sets spurious_err after reset is released.

Source files
------------

// File: rtl/cpu_mem_bus_arbiter.sv
// cpu_mem_bus_arbiter
// Registered arbiter between the dcache and icache miss paths and the
// single shared memory bus. It issues one transaction at a time and tags it
// with a requester id (0 = dcache, 1 = icache). The response carrying that
// id is routed back to the requester that issued the transaction.
// Dcache has fixed priority. After MAX_D_STREAK consecutive dcache grants
// while icache is waiting, icache is granted next.
//
// Ports
//   clock, reset          : system clock, asynchronous active-high reset
//   d_req_* / i_req_*     : requests, held by the requester until its grant
//   d_grant / i_grant     : one-cycle acceptance pulse (combinational, IDLE)
//   d_resp_* / i_resp_*   : routed response (combinational pass-through)
//   mem_req_*             : registered memory request; the strobe is high
//                           for exactly one cycle
//   mem_resp_*            : memory response with id
//   busy                  : a transaction is in flight
//   timeout_err           : sticky, a response wait was abandoned
//   spurious_err          : sticky, a response arrived with no matching
//                           outstanding id
module cpu_mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_req_read,
  input  logic                  d_req_write,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_data,
  output logic                  d_grant,
  output logic                  d_resp_valid,
  output logic [ADDR_WIDTH-1:0] d_resp_addr,
  output logic [DATA_WIDTH-1:0] d_resp_data,
  input  logic                  i_req_read,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  output logic                  i_grant,
  output logic                  i_resp_valid,
  output logic [ADDR_WIDTH-1:0] i_resp_addr,
  output logic [DATA_WIDTH-1:0] i_resp_data,
  output logic                  mem_req_id,
  output logic                  mem_req_read,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_resp_valid,
  input  logic                  mem_resp_id,
  input  logic [ADDR_WIDTH-1:0] mem_resp_addr,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  spurious_err
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [STREAK_W-1:0]   r_streak;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic                  r_mem_req_id;
  logic                  r_mem_req_read;
  logic                  r_mem_req_write;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;
  logic [DATA_WIDTH-1:0] r_mem_req_data;
  logic                  r_timeout_err;
  logic                  r_spurious_err;

  logic w_d_any;
  logic w_i_any;
  logic w_i_wins;
  logic w_d_wins;
  logic w_d_grant;
  logic w_i_grant;
  logic w_resp_match;
  logic w_tmo_hit;

  assign w_d_any = d_req_read | d_req_write;
  assign w_i_any = i_req_read | i_req_write;
  // Icache wins when it is the only requester, or when the dcache streak has saturated.
  assign w_i_wins = w_i_any & (~w_d_any | (r_streak == STREAK_MAX));
  assign w_d_wins = w_d_any & ~w_i_wins;
  // The pending id is the id of the last captured request.
  assign w_resp_match = mem_resp_valid & (r_state == S_WAIT) & (mem_resp_id == r_mem_req_id);
  assign w_tmo_hit    = (r_state == S_WAIT) & ~w_resp_match & (r_tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and grant decode
  always_comb begin
    w_next_state = r_state;
    w_d_grant    = 1'b0;
    w_i_grant    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // No grant is issued while reset is held, so nothing leaks out of an aborted cycle.
        if (reset) begin
          w_next_state = S_IDLE;
        end else if (w_d_wins) begin
          w_d_grant    = 1'b1;
          w_next_state = S_REQ;
        end else if (w_i_wins) begin
          w_i_grant    = 1'b1;
          w_next_state = S_REQ;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_REQ: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_resp_match || w_tmo_hit) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Request capture. The strobes are high only in REQ; id, addr and data hold until the next capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_req_id    <= 1'b0;
      r_mem_req_read  <= 1'b0;
      r_mem_req_write <= 1'b0;
      r_mem_req_addr  <= {ADDR_WIDTH{1'b0}};
      r_mem_req_data  <= {DATA_WIDTH{1'b0}};
    end else if (w_d_grant) begin
      r_mem_req_id    <= 1'b0;
      r_mem_req_read  <= d_req_read & ~d_req_write;  // write wins over read
      r_mem_req_write <= d_req_write;
      r_mem_req_addr  <= d_req_addr;
      r_mem_req_data  <= d_req_data;
    end else if (w_i_grant) begin
      r_mem_req_id    <= 1'b1;
      r_mem_req_read  <= i_req_read & ~i_req_write;
      r_mem_req_write <= i_req_write;
      r_mem_req_addr  <= i_req_addr;
      r_mem_req_data  <= i_req_data;
    end else begin
      r_mem_req_read  <= 1'b0;
      r_mem_req_write <= 1'b0;
    end
  end

  // Dcache streak counter that bounds icache starvation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_streak <= {STREAK_W{1'b0}};
    end else if (r_state == S_IDLE) begin
      if (w_i_grant || !w_i_any) begin
        r_streak <= {STREAK_W{1'b0}};
      end else if (w_d_grant && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + STREAK_W'(1);
      end else begin
        r_streak <= r_streak;
      end
    end else begin
      r_streak <= r_streak;
    end
  end

  // Timeout counter. It is zero in the first WAIT cycle and counts WAIT cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else if (r_state == S_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timeout_err  <= 1'b0;
      r_spurious_err <= 1'b0;
    end else begin
      r_timeout_err  <= r_timeout_err | w_tmo_hit;
      r_spurious_err <= r_spurious_err | (mem_resp_valid & ~w_resp_match);
    end
  end

  assign d_grant       = w_d_grant;
  assign i_grant       = w_i_grant;
  assign d_resp_valid  = w_resp_match & ~mem_resp_id;
  assign i_resp_valid  = w_resp_match & mem_resp_id;
  assign d_resp_addr   = mem_resp_addr;
  assign d_resp_data   = mem_resp_data;
  assign i_resp_addr   = mem_resp_addr;
  assign i_resp_data   = mem_resp_data;
  assign mem_req_id    = r_mem_req_id;
  assign mem_req_read  = r_mem_req_read;
  assign mem_req_write = r_mem_req_write;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_data  = r_mem_req_data;
  assign busy          = (r_state != S_IDLE);
  assign timeout_err   = r_timeout_err;
  assign spurious_err  = r_spurious_err;

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// Self-checking bench for cpu_mem_bus_arbiter. A transaction-level reference
// model tracks the one in-flight transaction and its age in cycles, the
// dcache streak and the sticky flags. Every cycle, the model predicts the
// grants, the memory request, the response routing and the error flags.
module tb_cpu_mem_bus_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic          clock;
  logic          reset;
  logic          d_req_read, d_req_write, i_req_read, i_req_write;
  logic [AW-1:0] d_req_addr, i_req_addr, d_resp_addr, i_resp_addr, mem_req_addr, mem_resp_addr;
  logic [DW-1:0] d_req_data, i_req_data, d_resp_data, i_resp_data, mem_req_data, mem_resp_data;
  logic          d_grant, i_grant, d_resp_valid, i_resp_valid;
  logic          mem_req_id, mem_req_read, mem_req_write;
  logic          mem_resp_valid, mem_resp_id;
  logic          busy, timeout_err, spurious_err;

  cpu_mem_bus_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .d_req_read(d_req_read), .d_req_write(d_req_write), .d_req_addr(d_req_addr), .d_req_data(d_req_data),
    .d_grant(d_grant), .d_resp_valid(d_resp_valid), .d_resp_addr(d_resp_addr), .d_resp_data(d_resp_data),
    .i_req_read(i_req_read), .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_grant(i_grant), .i_resp_valid(i_resp_valid), .i_resp_addr(i_resp_addr), .i_resp_data(i_resp_data),
    .mem_req_id(mem_req_id), .mem_req_read(mem_req_read), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_id(mem_resp_id),
    .mem_resp_addr(mem_resp_addr), .mem_resp_data(mem_resp_data),
    .busy(busy), .timeout_err(timeout_err), .spurious_err(spurious_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit            m_busy, m_id, m_rd, m_wr, m_tmo, m_spur, m_silent;
  int            m_age;     // 0 = strobe cycle, k >= 1 = k-th cycle awaiting response
  int            m_streak;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            exp_dg, exp_ig;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_id = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_tmo = 1'b0; m_spur = 1'b0;
    m_silent = 1'b0; m_age = 0; m_streak = 0; m_addr = '0; m_data = '0;
    exp_dg = 1'b0; exp_ig = 1'b0;
  endtask

  task automatic clear_inputs();
    d_req_read = 1'b0; d_req_write = 1'b0; d_req_addr = '0; d_req_data = '0;
    i_req_read = 1'b0; i_req_write = 1'b0; i_req_addr = '0; i_req_data = '0;
    mem_resp_valid = 1'b0; mem_resp_id = 1'b0; mem_resp_addr = '0; mem_resp_data = '0;
  endtask

  // Called right after inputs are driven at the falling edge: compare, then advance the model over the next rising edge.
  task automatic cycle_check();
    bit d_any, i_any, iw, dw, waiting, match, strobe;
    #1;
    d_any   = d_req_read | d_req_write;
    i_any   = i_req_read | i_req_write;
    iw      = !m_busy && i_any && (!d_any || m_streak == MAXS);
    dw      = !m_busy && d_any && !iw;
    exp_dg  = dw;
    exp_ig  = iw;
    waiting = m_busy && (m_age >= 1);
    match   = mem_resp_valid && waiting && (mem_resp_id == m_id);
    strobe  = m_busy && (m_age == 0);
    check_val("d_grant", d_grant, dw);
    check_val("i_grant", i_grant, iw);
    check_val("busy", busy, m_busy);
    check_val("mem_req_read", mem_req_read, strobe && m_rd);
    check_val("mem_req_write", mem_req_write, strobe && m_wr);
    check_val("mem_req_id", mem_req_id, m_id);
    check_val("mem_req_addr", mem_req_addr, m_addr);
    check_val("mem_req_data", mem_req_data, m_data);
    check_val("d_resp_valid", d_resp_valid, match && !m_id);
    check_val("i_resp_valid", i_resp_valid, match && m_id);
    if (match && !m_id) check_val("d_resp_data", d_resp_data, mem_resp_data);
    if (match && m_id) check_val("i_resp_addr", i_resp_addr, mem_resp_addr);
    check_val("timeout_err", timeout_err, m_tmo);
    check_val("spurious_err", spurious_err, m_spur);
    if (mem_resp_valid && !match) m_spur = 1'b1;
    if (!m_busy) begin
      if (dw || iw) begin
        m_busy = 1'b1; m_age = 0; m_id = iw;
        m_rd     = iw ? (i_req_read && !i_req_write) : (d_req_read && !d_req_write);
        m_wr     = iw ? i_req_write : d_req_write;
        m_addr   = iw ? i_req_addr : d_req_addr;
        m_data   = iw ? i_req_data : d_req_data;
        m_silent = ($urandom_range(0, 7) == 0);
      end
      if (iw || !i_any) m_streak = 0;
      else if (dw && m_streak < MAXS) m_streak++;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (match) begin
      m_busy = 1'b0;
    end else if (m_age == TMO) begin
      m_busy = 1'b0; m_tmo = 1'b1;
    end else begin
      m_age++;
    end
  endtask

  // mode 0: answer every awaited transaction at once; mode 1: random, wrong ids, silence, stray responses
  task automatic drive_resp(input int mode);
    int r;
    mem_resp_valid = 1'b0;
    mem_resp_id    = 1'b0;
    mem_resp_addr  = $urandom;
    mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
    if (m_busy && m_age >= 1) begin
      if (mode == 0) begin
        mem_resp_valid = 1'b1; mem_resp_id = m_id;
      end else if (!m_silent) begin
        r = $urandom_range(0, 9);
        if (r < 4) begin
          mem_resp_valid = 1'b1; mem_resp_id = m_id;
        end else if (r == 4) begin
          mem_resp_valid = 1'b1; mem_resp_id = !m_id;
        end
      end
    end else if (mode == 1 && $urandom_range(0, 14) == 0) begin
      mem_resp_valid = 1'b1; mem_resp_id = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      d_req_read = 1'b0; d_req_write = 1'b0; i_req_read = 1'b0; i_req_write = 1'b0;
      drive_resp(0);
      cycle_check();
      if (!m_busy && k > 0) break;
    end
    check_val("drain_idle", m_busy, 1'b0);
  endtask

  task automatic test_single_read();
    @(negedge clock);
    d_req_read = 1'b1; d_req_addr = 32'h0000_0100; d_req_data = '0;
    cycle_check();
    check_val("t1_grant", d_grant, 1'b1);
    @(negedge clock);
    d_req_read = 1'b0;
    cycle_check();
    check_val("t1_strobe", mem_req_read, 1'b1);
    check_val("t1_addr", mem_req_addr, 128'h100);
    @(negedge clock);
    cycle_check();
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_id = 1'b0; mem_resp_addr = 32'h0000_0100; mem_resp_data = 128'hAB;
    cycle_check();
    check_val("t1_resp_valid", d_resp_valid, 1'b1);
    check_val("t1_resp_data", d_resp_data, 128'hAB);
    check_val("t1_i_resp", i_resp_valid, 1'b0);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    cycle_check();
  endtask

  task automatic test_streak();
    logic [9:0] seq;
    int         n;
    seq = '0;
    n   = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clock);
      if (exp_dg) d_req_addr = $urandom;
      if (exp_ig) i_req_addr = $urandom;
      d_req_read = 1'b1; i_req_read = 1'b1;
      drive_resp(0);
      cycle_check();
      if (d_grant || i_grant) begin
        seq[n] = i_grant;
        n++;
      end
    end
    check_val("streak_count", n, 10);
    check_val("streak_order", seq, 10'b10_0001_0000);
    drain();
  endtask

  task automatic test_timeout();
    int got;
    got = -1;
    @(negedge clock);
    d_req_read = 1'b1; d_req_addr = 32'h0000_0200; i_req_read = 1'b1; i_req_addr = 32'h0000_0300;
    mem_resp_valid = 1'b0;
    cycle_check();
    check_val("tmo_d_first", d_grant, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      d_req_read = 1'b0;
      cycle_check();
      if (i_grant) begin
        got = k;
        break;
      end
    end
    check_val("tmo_i_grant_cycle", got, 10);
    check_val("tmo_err", timeout_err, 1'b1);
    drain();
  endtask

  task automatic test_random(input int cycles);
    int kind;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      if (exp_dg) begin d_req_read = 1'b0; d_req_write = 1'b0; end
      if (exp_ig) begin i_req_read = 1'b0; i_req_write = 1'b0; end
      if (!(d_req_read | d_req_write) && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        d_req_read = (kind != 1); d_req_write = (kind != 0);
        d_req_addr = $urandom; d_req_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!(i_req_read | i_req_write) && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 2);
        i_req_read = (kind != 1); i_req_write = (kind != 0);
        i_req_addr = $urandom; i_req_data = {$urandom, $urandom, $urandom, $urandom};
      end
      drive_resp(1);
      cycle_check();
    end
    drain();
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    d_req_write = 1'b1; d_req_addr = 32'h0000_0400; d_req_data = 128'h55;
    cycle_check();
    @(negedge clock);
    d_req_write = 1'b0;
    cycle_check();
    @(negedge clock);
    cycle_check();
    check_val("ar_in_wait", busy, 1'b1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    d_req_read = 1'b1;
    #1;
    check_val("ar_busy", busy, 1'b0);
    check_val("ar_read", mem_req_read, 1'b0);
    check_val("ar_write", mem_req_write, 1'b0);
    check_val("ar_no_grant", d_grant, 1'b0);
    check_val("ar_tmo_clr", timeout_err, 1'b0);
    model_reset();
    @(negedge clock);
    d_req_read = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_id = 1'b0;
    cycle_check();
    check_val("ar_late_no_resp", d_resp_valid, 1'b0);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    cycle_check();
    check_val("ar_spurious", spurious_err, 1'b1);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_read", mem_req_read, 1'b0);
    check_val("rst_write", mem_req_write, 1'b0);
    check_val("rst_id", mem_req_id, 1'b0);
    check_val("rst_addr", mem_req_addr, '0);
    check_val("rst_tmo", timeout_err, 1'b0);
    check_val("rst_spur", spurious_err, 1'b0);
    reset = 1'b0;
    test_single_read();
    drain();
    test_streak();
    test_timeout();
    test_random(3000);
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
